// File: rtl/ym3438_lfo_pkg.sv
// Shared constants and types for the OPN2 LFO successor.
// Contents: rate prescaler table, PM multiplier table, noise LFSR taps,
// and the waveform select enum.
package ym3438_lfo_pkg;

   // Ticks per LFO phase step, indexed by rate select.
   localparam logic [6:0] RATE_DIV [8] = '{7'd108, 7'd77, 7'd71, 7'd67,
                                           7'd62,  7'd44, 7'd8,  7'd5};

   // PM multiplier, indexed [pms][pm_val]; row 0 disables PM.
   localparam logic [4:0] PM_MULT [8][8] = '{
      '{5'd0, 5'd0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0},
      '{5'd0, 5'd0, 5'd0,  5'd0,  5'd1,  5'd1,  5'd1,  5'd1},
      '{5'd0, 5'd0, 5'd1,  5'd1,  5'd2,  5'd2,  5'd2,  5'd3},
      '{5'd0, 5'd0, 5'd1,  5'd2,  5'd2,  5'd2,  5'd3,  5'd4},
      '{5'd0, 5'd1, 5'd2,  5'd3,  5'd4,  5'd4,  5'd5,  5'd6},
      '{5'd0, 5'd1, 5'd3,  5'd4,  5'd6,  5'd6,  5'd7,  5'd9},
      '{5'd0, 5'd2, 5'd4,  5'd6,  5'd8,  5'd8,  5'd10, 5'd12},
      '{5'd0, 5'd4, 5'd8,  5'd12, 5'd16, 5'd16, 5'd20, 5'd24}
   };

   // Galois feedback polynomial x^16 + x^14 + x^13 + x^11 + 1 (right shift).
   localparam logic [15:0] NOISE_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      LFO_TRI   = 2'd0,
      LFO_SAW   = 2'd1,
      LFO_SQR   = 2'd2,
      LFO_NOISE = 2'd3
   } lfo_wave_e;

endpackage

// File: rtl/ym3438_lfo_pm_scale.sv
// Combinational PM scaler: {fnum,0} +/- ((fnum[hi] * mult) >> 3), saturated.
// Ports:
//   fnum   - channel F-number
//   pms    - PM sensitivity (row of PM_MULT)
//   pm_val - PM depth index (column of PM_MULT)
//   sign   - 1 subtracts the offset
//   sum    - saturated result in [0, 2^(FNUM_W+1)-1]
module ym3438_lfo_pm_scale
   import ym3438_lfo_pkg::*;
#(
   parameter int unsigned FNUM_W = 11
) (
   input  logic [FNUM_W-1:0] fnum,
   input  logic [2:0]        pms,
   input  logic [2:0]        pm_val,
   input  logic              sign,
   output logic [FNUM_W:0]   sum
);

   localparam int unsigned HI_W   = FNUM_W - 4;
   localparam int unsigned PROD_W = HI_W + 5;
   localparam int unsigned SUM_W  = FNUM_W + 2;

   logic [4:0]        mult;
   logic [PROD_W-1:0] prod;
   logic [PROD_W-1:0] off;
   logic [SUM_W-1:0]  base;
   logic [SUM_W-1:0]  raw;

   // One guard bit above the result catches both overflow and underflow.
   always_comb begin
      mult = PM_MULT[pms][pm_val];
      prod = PROD_W'(fnum[FNUM_W-1:4]) * PROD_W'(mult);
      off  = prod >> 3;
      base = {1'b0, fnum, 1'b0};
      raw  = sign ? (base - SUM_W'(off)) : (base + SUM_W'(off));
      if (raw[SUM_W-1])
         sum = sign ? '0 : '1;
      else
         sum = raw[FNUM_W:0];
   end

endmodule

// File: rtl/ym3438_lfo_gen.sv
// OPN2 LFO successor: rate prescaler, phase counter, four AM waveforms,
// noise LFSR and PM-adjusted F-number. All outputs registered on MCLK.
// Ports:
//   MCLK, IC     - master clock, synchronous active-high reset
//   tick         - one-cycle strobe per sample frame
//   lfo_en, rate - LFO enable and rate select
//   wave         - waveform select (lfo_wave_e)
//   sync         - phase restart pulse, beats tick
//   pms, fnum    - PM sensitivity and channel F-number
//   lfo_am       - AM attenuation (0 = none)
//   lfo_pm_sign  - 1 = negative PM offset
//   fnum_lfo     - {fnum,0} +/- PM offset, saturated
//   phase        - LFO phase counter
//   phase_step   - one-cycle pulse after each phase advance
module ym3438_lfo_gen
   import ym3438_lfo_pkg::*;
#(
   parameter int unsigned SUB_W   = 7,
   parameter int unsigned CNT_W   = 7,
   parameter int unsigned FNUM_W  = 11,
   parameter int unsigned NOISE_W = 16
) (
   input  logic                MCLK,
   input  logic                IC,
   input  logic                tick,
   input  logic                lfo_en,
   input  logic [2:0]          rate,
   input  logic [1:0]          wave,
   input  logic                sync,
   input  logic [2:0]          pms,
   input  logic [FNUM_W-1:0]   fnum,
   output logic [CNT_W-2:0]    lfo_am,
   output logic                lfo_pm_sign,
   output logic [FNUM_W:0]     fnum_lfo,
   output logic [CNT_W-1:0]    phase,
   output logic                phase_step
);

   localparam int unsigned AM_W = CNT_W - 1;

   logic [SUB_W-1:0]   sub;
   logic [NOISE_W-1:0] lfsr;
   logic [SUB_W-1:0]   div_last;
   logic [NOISE_W-1:0] lfsr_next;
   lfo_wave_e          wave_sel;
   logic [AM_W-1:0]    am_c;
   logic [2:0]         pm_val_c;
   logic               sign_c;
   logic [FNUM_W:0]    sum_c;

   assign div_last = SUB_W'(RATE_DIV[rate]) - SUB_W'(1);
   assign wave_sel = lfo_wave_e'(wave);

   // Galois step; a non-zero state never maps to zero.
   assign lfsr_next = {1'b0, lfsr[NOISE_W-1:1]}
                    ^ (lfsr[0] ? NOISE_W'(NOISE_TAPS) : '0);

   // Waveform shaping and PM index from the current phase (or LFSR for noise).
   always_comb begin
      am_c     = '0;
      pm_val_c = phase[CNT_W-3:CNT_W-5] ^ {3{phase[CNT_W-2]}};
      sign_c   = phase[CNT_W-1];
      case (wave_sel)
         LFO_TRI:   am_c = phase[AM_W-1:0] ^ {AM_W{phase[CNT_W-1]}};
         LFO_SAW:   am_c = phase[CNT_W-1:1];
         LFO_SQR:   am_c = {AM_W{phase[CNT_W-1]}};
         LFO_NOISE: begin
            am_c     = lfsr[AM_W-1:0];
            pm_val_c = lfsr[2:0];
            sign_c   = lfsr[AM_W];
         end
         default:   am_c = '0;
      endcase
   end

   ym3438_lfo_pm_scale #(
      .FNUM_W (FNUM_W)
   ) u_pm_scale (
      .fnum   (fnum),
      .pms    (pms),
      .pm_val (pm_val_c),
      .sign   (sign_c),
      .sum    (sum_c)
   );

   // Prescaler/phase/LFSR state and registered outputs.
   // Priority: IC > (disable | sync) > tick. The >= compare lets a switch
   // to a shorter divider wrap on the next tick instead of overrunning.
   always_ff @(posedge MCLK) begin
      if (IC) begin
         sub         <= '0;
         phase       <= '0;
         phase_step  <= 1'b0;
         lfsr        <= NOISE_W'(1);
         lfo_am      <= '0;
         lfo_pm_sign <= 1'b0;
         fnum_lfo    <= '0;
      end else begin
         phase_step <= 1'b0;
         if (!lfo_en || sync) begin
            sub   <= '0;
            phase <= '0;
         end else if (tick) begin
            if (sub >= div_last) begin
               sub        <= '0;
               phase      <= phase + CNT_W'(1);
               phase_step <= 1'b1;
               lfsr       <= lfsr_next;
            end else begin
               sub <= sub + SUB_W'(1);
            end
         end
         lfo_am      <= lfo_en ? am_c : '0;
         lfo_pm_sign <= lfo_en & sign_c;
         fnum_lfo    <= lfo_en ? sum_c : {fnum, 1'b0};
      end
   end

endmodule

// File: tb/tb_ym3438_lfo_gen.sv
// Directed self-checking bench for ym3438_lfo_gen.
module tb_ym3438_lfo_gen;

   logic        MCLK = 1'b0;
   logic        IC;
   logic        tick;
   logic        lfo_en;
   logic [2:0]  rate;
   logic [1:0]  wave;
   logic        sync;
   logic [2:0]  pms;
   logic [10:0] fnum;
   logic [5:0]  lfo_am;
   logic        lfo_pm_sign;
   logic [11:0] fnum_lfo;
   logic [6:0]  phase;
   logic        phase_step;

   int passed = 0;
   int total  = 0;

   ym3438_lfo_gen dut (
      .MCLK        (MCLK),
      .IC          (IC),
      .tick        (tick),
      .lfo_en      (lfo_en),
      .rate        (rate),
      .wave        (wave),
      .sync        (sync),
      .pms         (pms),
      .fnum        (fnum),
      .lfo_am      (lfo_am),
      .lfo_pm_sign (lfo_pm_sign),
      .fnum_lfo    (fnum_lfo),
      .phase       (phase),
      .phase_step  (phase_step)
   );

   always #5 MCLK = ~MCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge MCLK);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   // Tick until phase reaches target, bounded.
   task automatic run_to(input int target);
      int n = 0;
      while (phase !== 7'(target) && n < 1000) begin
         do_tick();
         n++;
      end
      check($sformatf("run_to_%0d", target), 32'(phase), 32'(target));
   endtask

   initial begin
      int steps;
      int changes;
      logic [15:0] model;
      logic [5:0]  prev_am;

      IC = 1'b1; tick = 1'b0; lfo_en = 1'b0; rate = 3'd0; wave = 2'd0;
      sync = 1'b0; pms = 3'd0; fnum = 11'h123;
      cyc(); cyc();
      check("rst_phase",  32'(phase), 32'd0);
      check("rst_am",     32'(lfo_am), 32'd0);
      check("rst_sign",   32'(lfo_pm_sign), 32'd0);
      check("rst_fnum",   32'(fnum_lfo), 32'd0);
      check("rst_step",   32'(phase_step), 32'd0);

      // Ten ticks at divider 5: two phase steps
      IC = 1'b0; lfo_en = 1'b1; rate = 3'd7; wave = 2'd0;
      steps = 0;
      for (int i = 0; i < 10; i++) begin
         do_tick();
         if (phase_step) steps++;
      end
      check("ten_phase", 32'(phase), 32'd2);
      check("ten_steps", 32'(steps), 32'd2);
      cyc();
      check("ten_am",    32'(lfo_am), 32'd2);
      check("pms0_fnum", 32'(fnum_lfo), 32'h246);

      // PM positive half, pm_val=7
      run_to(28);
      pms = 3'd7; fnum = 11'h400;
      cyc();
      check("pm_pos",      32'(fnum_lfo), 32'h8C0);
      check("pm_pos_sign", 32'(lfo_pm_sign), 32'd0);
      fnum = 11'h7FF;
      cyc();
      check("pm_sat",      32'(fnum_lfo), 32'hFFF);

      // Triangle peak and fold
      run_to(63); cyc();
      check("tri_63", 32'(lfo_am), 32'd63);
      run_to(64); cyc();
      check("tri_64", 32'(lfo_am), 32'd63);

      // PM negative half, pm_val=7
      run_to(92); cyc();
      check("pm_neg_7ff",  32'(fnum_lfo), 32'hE81);
      check("pm_neg_sign", 32'(lfo_pm_sign), 32'd1);
      fnum = 11'h400;
      cyc();
      check("pm_neg",      32'(fnum_lfo), 32'h740);

      run_to(127); cyc();
      check("tri_127", 32'(lfo_am), 32'd0);
      run_to(0); cyc();
      check("tri_wrap",  32'(lfo_am), 32'd0);
      check("pm_zero",   32'(fnum_lfo), 32'h800);

      // sync beats tick
      run_to(40);
      sync = 1'b1; tick = 1'b1;
      cyc();
      sync = 1'b0; tick = 1'b0;
      check("sync_phase", 32'(phase), 32'd0);
      check("sync_step",  32'(phase_step), 32'd0);
      for (int i = 0; i < 4; i++) do_tick();
      check("sync_sub_hold", 32'(phase), 32'd0);
      do_tick();
      check("sync_sub_wrap", 32'(phase), 32'd1);

      // IC beats sync and tick
      do_tick(); do_tick();
      IC = 1'b1; sync = 1'b1; tick = 1'b1;
      cyc();
      check("ic_phase", 32'(phase), 32'd0);
      check("ic_step",  32'(phase_step), 32'd0);
      check("ic_am",    32'(lfo_am), 32'd0);
      check("ic_fnum",  32'(fnum_lfo), 32'd0);
      check("ic_sign",  32'(lfo_pm_sign), 32'd0);
      IC = 1'b0; sync = 1'b0; tick = 1'b0;

      // Rate change to a shorter divider wraps on the next tick
      rate = 3'd0;
      for (int i = 0; i < 50; i++) do_tick();
      check("rate0_hold", 32'(phase), 32'd0);
      rate = 3'd7;
      do_tick();
      check("rate_sw_phase", 32'(phase), 32'd1);
      check("rate_sw_step",  32'(phase_step), 32'd1);
      for (int i = 0; i < 4; i++) do_tick();
      check("rate_sw_sub0", 32'(phase), 32'd1);
      do_tick();
      check("rate_sw_next", 32'(phase), 32'd2);

      // Noise from a fresh LFSR
      IC = 1'b1; cyc(); IC = 1'b0;
      wave = 2'd3; pms = 3'd0; fnum = 11'h000;
      model = 16'h0001; changes = 0; prev_am = 6'd0;
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < 5; i++) do_tick();
         model = {1'b0, model[15:1]} ^ (model[0] ? 16'hB400 : 16'h0000);
         cyc();
         check($sformatf("noise_am_%0d", k),   32'(lfo_am), 32'(model[5:0]));
         check($sformatf("noise_sign_%0d", k), 32'(lfo_pm_sign), 32'(model[6]));
         if (k > 0 && lfo_am !== prev_am) changes++;
         prev_am = lfo_am;
      end
      check("noise_moves", 32'(changes > 0), 32'd1);

      // Disable
      lfo_en = 1'b0; fnum = 11'h155; pms = 3'd7;
      cyc();
      check("dis_am",    32'(lfo_am), 32'd0);
      check("dis_sign",  32'(lfo_pm_sign), 32'd0);
      check("dis_fnum",  32'(fnum_lfo), 32'h2AA);
      check("dis_phase", 32'(phase), 32'd0);
      for (int i = 0; i < 6; i++) do_tick();
      check("dis_hold",  32'(phase), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ym3438_lfo_gen.md
Name: ym3438_lfo_gen

Overview:
Parametrised successor LFO for the OPN2 core, generating AM attenuation and PM-adjusted F-number for the operator pipeline.
Adds four waveforms: triangle, saw, square and LFSR noise.
Adds a table-driven rate prescaler, key-sync phase restart and saturating PM arithmetic.
Runs on MCLK, gated by a per-sample tick strobe from the FSM, and sits between the register file and the phase generator.

Parameters:
SUB_W, 7, prescaler counter width
CNT_W, 7, LFO phase counter width (min 7); AM_W = CNT_W-1
FNUM_W, 11, F-number width (min 8)
NOISE_W, 16, noise LFSR width

Ports:
MCLK  in  1  master clock
IC  in  1  synchronous active-high reset
tick  in  1  one-cycle strobe, once per sample frame
lfo_en  in  1  LFO enable (reg 0x22 bit 3)
rate  in  3  rate select (reg 0x22 bits 2:0)
wave  in  2  waveform: 0 triangle, 1 saw, 2 square, 3 noise
sync  in  1  phase restart pulse (key-on sync)
pms  in  3  PM sensitivity
fnum  in  FNUM_W  channel F-number
lfo_am  out  AM_W  AM attenuation, 0 = none
lfo_pm_sign  out  1  1 = negative PM offset
fnum_lfo  out  FNUM_W+1  {fnum,0} + signed PM offset, saturated
phase  out  CNT_W  current phase, debug/test
phase_step  out  1  one-cycle pulse when phase advances

Behaviour:
- Reset (IC=1 at a MCLK edge):
  - sub, phase, lfo_am, lfo_pm_sign and phase_step go to 0.
  - fnum_lfo goes to 0.
  - The LFSR loads 1.
  - Reset has priority over every other input, including mid-count.
- Prescaler:
  - Triggered on tick with lfo_en=1.
  - If sub >= RATE_DIV[rate]-1: sub <= 0, phase <= phase+1 (wraps mod 2^CNT_W), and phase_step pulses on the next cycle. Otherwise sub <= sub+1.
  - Using >= means a rate change to a shorter divider wraps on the next tick, never overruns.
- lfo_en=0: sub and phase held at 0. lfo_am=0, lfo_pm_sign=0, fnum_lfo={fnum,0}. The LFSR holds its value.
- sync=1: sub and phase go to 0 on that edge, independent of tick. sync beats tick when both are high on the same edge.
- LFSR: Galois, taps NOISE_TAPS. Advances only on a phase increment and never reaches all-zero.
- Waveforms (lfo_am registered, 1 MCLK after phase update):
  - triangle: lfo_am = phase[AM_W-1:0] ^ {AM_W{phase[CNT_W-1]}}
  - saw: lfo_am = phase[CNT_W-1:1]
  - square: lfo_am = phase[CNT_W-1] ? all-ones : 0
  - noise: lfo_am = lfsr[AM_W-1:0], sampled when phase increments
- PM:
  - pm_val = phase[CNT_W-3:CNT_W-5] ^ {3{phase[CNT_W-2]}}.
  - lfo_pm_sign = phase[CNT_W-1]. In noise mode, lfo_pm_sign = lfsr[AM_W] and pm_val = lfsr[2:0].
  - mult = PM_MULT[pms][pm_val], 5 bit. pms=0 gives mult=0.
  - off = (fnum[FNUM_W-1:4] * mult) >> 3.
  - sum = {fnum,0} ± off, computed in FNUM_W+2 bits, then saturated to [0, 2^(FNUM_W+1)-1].
  - fnum_lfo is registered, 1 MCLK latency from a fnum, pms or phase change.
- Outputs change only on MCLK edges, and all outputs are registered.

Decomposition:
- Package ym3438_lfo_pkg holds:
  - RATE_DIV[8] = {108,77,71,67,62,44,8,5}
  - PM_MULT[8][8]; pms7 row = {0,4,8,12,16,16,20,24}, pms1 row = {0,0,0,0,1,1,1,1}
  - NOISE_TAPS = 16'hB400
  - the waveform enum: LFO_TRI, LFO_SAW, LFO_SQR, LFO_NOISE
- One sub-module, ym3438_lfo_pm_scale. It is combinational: fnum, pms, pm_val and sign in, saturated sum out. This lets it be reused by the CSM/Ch3 special-mode path.

Test Plan:
- Reset: IC=1 for 2 cycles, then lfo_en=1, rate=7, wave=0, 10 ticks → phase=2, phase_step pulses exactly twice, lfo_am=2.
- Triangle wrap: rate=7, run to phase=63 → lfo_am=63; phase=64 → lfo_am=63; phase=127 → lfo_am=0; next step phase=0, lfo_am=0.
- Sync/priority: at phase=40, assert sync and tick on the same edge → phase=0 and sub=0 next cycle, no phase_step. Assert IC with sync → all zero.
- Rate change: rate=0, sub=50, switch to rate=7 → phase increments on the next tick, sub=0.
- PM: pms=7, fnum=11'h400, pm_val=7, sign=0 → fnum_lfo=12'h8C0; with sign=1 → 12'h740. fnum=11'h7FF, pm_val=7, sign=0 → 12'hFFF (saturated).
- Noise/disable: wave=3, 20 phase steps → lfo_am never static for the whole run, LFSR never 0. lfo_en=0 → lfo_am=0 and fnum_lfo={fnum,0} next cycle.
